// File: rtl/base58_seq_encoder.sv
// Sequential base-58 ASCII encoder: a shared bit-serial divide-by-58 datapath produces
// digits LSB first into a buffer, which is then streamed MSB first over valid/ready.
module base58_seq_encoder #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int unsigned REM_W = 7;
    localparam int unsigned DIG_W = 6;
    localparam int unsigned BIT_W = $clog2(IN_W + 1);
    localparam int unsigned IDX_W = $clog2(DIGITS + 1);

    // Number of base-58 digits needed for the largest IN_W-bit operand.
    function automatic int unsigned digits_needed();
        logic [IN_W-1:0] v;
        int unsigned     n;
        v = '1;
        n = 0;
        for (int i = 0; i < IN_W; i++) begin
            if (v != '0) begin
                v = v / IN_W'(58);
                n++;
            end
        end
        return n;
    endfunction

    if (DIGITS < digits_needed()) begin : g_digits_check
        $fatal(1, "base58_seq_encoder: DIGITS too small for IN_W");
    end

    function automatic logic [7:0] to_ascii(input logic [DIG_W-1:0] d);
        if (d < DIG_W'(10))      return 8'(d) + 8'd48;
        else if (d < DIG_W'(36)) return 8'(d) + 8'd55;
        else                     return 8'(d) + 8'd61;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_EMIT} state_e;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    div_q, div_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIG_W-1:0]   dig_q [DIGITS];
    logic [DIG_W-1:0]   dig_d [DIGITS];
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;

    logic [REM_W-1:0]   rem_sh, rem_n;
    logic               q_bit;
    logic [IN_W-1:0]    quo_n;

    // One restoring-division step: shift in the dividend MSB, conditionally subtract 58.
    always_comb begin
        rem_sh = {rem_q[DIG_W-1:0], div_q[IN_W-1]};
        q_bit  = (rem_sh >= REM_W'(58));
        rem_n  = q_bit ? (rem_sh - REM_W'(58)) : rem_sh;
        quo_n  = {div_q[IN_W-2:0], q_bit};
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        rem_d       = rem_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dig_d       = dig_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    div_d      = in_data;
                    rem_d      = '0;
                    bit_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_DIV;
                end
            end
            S_DIV: begin
                div_d = quo_n;
                rem_d = rem_n;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(IN_W - 1)) begin
                    dig_d[cnt_q] = rem_n[DIG_W-1:0];
                    cnt_d        = cnt_q + IDX_W'(1);
                    bit_d        = '0;
                    rem_d        = '0;
                    // The digit just produced is the most significant one: present it directly.
                    if (quo_n == '0) begin
                        idx_d       = cnt_q;
                        out_valid_d = 1'b1;
                        out_data_d  = to_ascii(rem_n[DIG_W-1:0]);
                        out_last_d  = (cnt_q == '0);
                        state_d     = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (idx_q == '0) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d      = idx_q - IDX_W'(1);
                        out_data_d = to_ascii(dig_q[idx_q - IDX_W'(1)]);
                        out_last_d = (idx_q == IDX_W'(1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            rem_q       <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            for (int i = 0; i < DIGITS; i++) dig_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dig_q       <= dig_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_base58_seq_encoder.sv
// Bench for base58_seq_encoder: directed and random operands compared against an
// arithmetic base-58 reference built from an alphabet string.
module tb_base58_seq_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;
    string alpha = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuv";
    byte exp_q[$];

    base58_seq_encoder #(.IN_W(32), .DIGITS(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: repeated division with the remainder indexing the alphabet, MSB digit first.
    function automatic void build(input logic [31:0] v);
        longint unsigned x;
        x = 64'(v);
        exp_q.delete();
        do begin
            exp_q.push_front(alpha[int'(x % 58)]);
            x = x / 58;
        end while (x != 0);
    endfunction

    task automatic run_op(input logic [31:0] v, input int stall_beat, input int stall_len,
                          input bit junk);
        int n;
        build(v);
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = junk;
        chk("busy_div", 32'(busy), 32'd1);
        chk("in_ready_div", 32'(in_ready), 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 2000) begin
            if (junk) in_data = $urandom;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'(32 * exp_q.size()));
        foreach (exp_q[i]) begin
            if (i == stall_beat) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(exp_q[i]));
                end
                out_ready = 1'b1;
            end
            chk("beat_valid", 32'(out_valid), 32'd1);
            chk("beat_data", 32'(out_data), 32'(exp_q[i]));
            chk("beat_last", 32'(out_last), 32'(i == exp_q.size() - 1));
            @(negedge clk);
        end
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd0, -1, 0, 1'b0);
        run_op(32'd57, -1, 0, 1'b0);
        run_op(32'd58, -1, 0, 1'b0);
        run_op(32'hFFFF_FFFF, -1, 0, 1'b0);
        run_op(32'd3363, 0, 5, 1'b0);
        run_op(32'd3363, 1, 5, 1'b0);
        run_op(32'd123456789, -1, 0, 1'b1);
        for (int k = 0; k < 10; k++)
            run_op($urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));

        // Reset in the middle of division.
        in_valid = 1'b1;
        in_data  = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstdiv_valid", 32'(out_valid), 32'd0);
        chk("rstdiv_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstdiv_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of emission, with output stalled.
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("rstemit_reach", 32'(out_valid), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstemit_valid", 32'(out_valid), 32'd0);
        chk("rstemit_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstemit_no_resume", 32'(out_valid), 32'd0);
        end
        chk("rstemit_in_ready", 32'(in_ready), 32'd1);
        run_op(32'd58, -1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/base58_seq_encoder.md
Name: base58_seq_encoder

Overview:
- Sequential base-58 ASCII encoder for IN_W-bit unsigned values.
- Uses one shared iterative divide-by-58 datapath, one quotient bit per cycle, repeated once per digit.
- Collects digits least-significant first into a buffer, then streams them most-significant first as ASCII over a valid/ready interface.
- Replaces the three-digit combinational converter wherever wider operands or area savings are needed.

Parameters:
- IN_W, 32, input operand width in bits.
- DIGITS, 6, digit buffer depth. Must satisfy 58^DIGITS >= 2^IN_W; a violation is a fatal elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  IN_W  unsigned operand.
- out_valid  output  1  ASCII character valid.
- out_ready  input  1  downstream accepts the character.
- out_data  output  8  ASCII character.
- out_last  output  1  marks the final (least-significant) character of a number.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state goes to IDLE; out_valid=0, out_data=8'h00, out_last=0, busy=0, in_ready=1.
  - Dividend, remainder, digit count, index and buffer are cleared.
- Character mapping, per digit d in 0..57:
  - d<10 -> d+48 ('0'-'9').
  - d<36 -> d+55 ('A'-'Z').
  - otherwise -> d+61 ('a'-'v').
  - This is a fixed alphabet, not the Bitcoin alphabet.
- State machine IDLE / DIV / EMIT:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data as the dividend, clear the remainder, bit counter and digit count, then go to DIV.
  - DIV (in_ready=0, busy=1):
    - Each cycle: rem = {rem[5:0], dividend MSB}; dividend shifts left.
    - If rem>=58: rem -= 58 and quotient bit = 1, else 0. The quotient bits shift into the dividend LSB.
    - Width rules: rem is 7 bits wide; after the compare/subtract it is always <58.
    - After IN_W cycles, on that same edge: write rem into buf[count]; count++.
    - If the quotient is 0, go to EMIT with idx = count-1 (the new count).
    - Otherwise keep the quotient as the next dividend, clear rem, and stay in DIV.
  - EMIT:
    - out_valid=1, out_data = map(buf[idx]), out_last = (idx==0).
    - On out_valid&&out_ready: if idx==0 go to IDLE, else idx--.
    - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- No leading zeros are emitted. Operand 0 produces exactly one digit, '0'.
- Latency:
  - An n-digit result needs n*IN_W DIV cycles.
  - The first out_valid comes in the cycle after the last DIV cycle.
  - With out_ready held at 1, one character transfers per cycle.
- Back-to-back operands: in_ready rises in the cycle after the out_last handshake. There is no overlap between operands.
- in_valid while busy is ignored; the operand is not captured.
- Reset asserted in DIV or EMIT aborts immediately:
  - out_valid drops asynchronously.
  - No partial output resumes after release.
- No combinational path from in_valid/in_data to any output, or from out_ready to out_valid/out_data.

Test Plan:
- Operand 0 -> after 32 DIV cycles, a single beat: out_data=8'h30, out_last=1. in_ready is back to 1 in the next cycle.
- Operand 57 -> single beat 8'h76 ('v'), last=1. Operand 58 -> beats 8'h31, 8'h30; last only on the second beat. The 58 case takes 64 DIV cycles.
- Operand 32'hFFFFFFFF (digits 6,31,30,48,8,15) -> "6VUm8F" = 36,56,55,6D,38,46 hex. First out_valid 192 cycles after acceptance. Six consecutive beats with out_ready=1.
- Backpressure: operand 3363 ("ZZ" = 5A,5A, two digits of 57? no: 3363 = 57*58+57 -> "vv" = 76,76).
  - Hold out_ready=0 for 5 cycles in EMIT.
  - out_valid stays 1 and out_data stays 8'h76 unchanged; no beat is lost or duplicated.
- in_valid held high with changing in_data during DIV -> ignored. The output matches the first accepted operand only, and the next operand is accepted after the last beat.
- Assert rst_n=0 mid-DIV and again mid-EMIT -> out_valid=0 and busy=0 immediately, in_ready=1 after release. A subsequent operand 58 yields exactly "10".
